recirc_lanes: RTL

RECIRC_LANES -- requirements
Module: recirc_lanes

---
 rtl/recirc_pkg.sv | 19 +
 rtl/recirc_lane.sv | 67 ++++++
 rtl/recirc_lanes.sv | 127 ++++++++++++
 3 files changed

// File: rtl/recirc_pkg.sv
// Shared types and default parameter values for the recirc_lanes block.
// Contents: the FSM state enum and the LANES/DW/SETTLE/CNT_W defaults.
package recirc_pkg;

    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_DW     = 8;
    localparam int unsigned DEF_SETTLE = 2;
    localparam int unsigned DEF_CNT_W  = 8;

    // Settle counter width; covers SETTLE up to 15.
    localparam int unsigned SCNT_W = 4;

    typedef enum logic [1:0] {
        RECIRC = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/recirc_lane.sv
// One lane of recirc_lanes: path select, output registers, recirculation counter.
// Ports:
//   clk, reset_L          - clock, synchronous active-low reset
//   fwd                   - 1: the word goes to L1, 0: the word recirculates
//   vin, din              - lane valid and data
//   clr                   - counter clear (used only with RECIRC_CNT_EN)
//   L1_data, L1_valid     - registered forward path
//   rc_data, rc_valid     - registered recirculation path
//   rc_cnt                - recirculated-word counter (constant 0 without RECIRC_CNT_EN)
// Build option: define RECIRC_CNT_EN to instantiate the saturating counter.
module recirc_lane
    import recirc_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             fwd,
    input  logic             vin,
    input  logic [DW-1:0]    din,
    input  logic             clr,
    output logic [DW-1:0]    L1_data,
    output logic             L1_valid,
    output logic [DW-1:0]    rc_data,
    output logic             rc_valid,
    output logic [CNT_W-1:0] rc_cnt
);

    // Invalid lanes present zero so no stale data is ever visible.
    logic [DW-1:0] word_c;
    assign word_c = vin ? din : '0;

    // Exactly one path carries the word; the other is forced to zero.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            L1_data  <= '0;
            L1_valid <= 1'b0;
            rc_data  <= '0;
            rc_valid <= 1'b0;
        end else begin
            L1_valid <= fwd & vin;
            L1_data  <= fwd ? word_c : '0;
            rc_valid <= ~fwd & vin;
            rc_data  <= fwd ? '0 : word_c;
        end
    end

`ifdef RECIRC_CNT_EN
    // Saturating count of recirculated words; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rc_cnt <= '0;
        end else if (clr) begin
            rc_cnt <= '0;
        end else if (!fwd && vin && (rc_cnt != '1)) begin
            rc_cnt <= rc_cnt + CNT_W'(1);
        end
    end
`else
    assign rc_cnt = '0;

    logic unused_clr;
    assign unused_clr = clr;
`endif

endmodule

// File: rtl/recirc_lanes.sv
// Multi-lane router: words recirculate until the link has been idle-complete
// (IDL high) long enough, then forward to L1; an IDL drop switches back at once.
// Ports:
//   clk, reset_L       - clock, synchronous active-low reset
//   IDL                - idle-complete indication
//   data_in, valid_in  - LANES packed lanes of DW bits, per-lane valid
//   clr_cnt            - clear all recirculation counters
//   L1_data, L1_valid  - forwarded words (1-cycle latency)
//   rc_data, rc_valid  - recirculated words (1-cycle latency)
//   active             - high while forwarded words are being presented
//   rc_cnt             - per-lane recirculated-word counters, CNT_W bits each
// Build option: define RECIRC_CNT_EN to enable the per-lane counters.
module recirc_lanes
    import recirc_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned SETTLE = DEF_SETTLE,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   IDL,
    input  logic [LANES*DW-1:0]    data_in,
    input  logic [LANES-1:0]       valid_in,
    input  logic                   clr_cnt,
    output logic [LANES*DW-1:0]    L1_data,
    output logic [LANES-1:0]       L1_valid,
    output logic [LANES*DW-1:0]    rc_data,
    output logic [LANES-1:0]       rc_valid,
    output logic                   active,
    output logic [LANES*CNT_W-1:0] rc_cnt
);

    state_t            state, state_nxt;
    logic [SCNT_W-1:0] scnt, scnt_nxt;
    logic              fwd_c;

    // State and settle count registers.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= RECIRC;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
        end
    end

    // Next-state logic: IDL must stay high through the settle window.
    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        unique case (state)
            RECIRC: begin
                if (IDL) begin
                    if (SETTLE == 1) begin
                        state_nxt = ACTIVE;
                        scnt_nxt  = '0;
                    end else begin
                        state_nxt = ARM;
                        scnt_nxt  = SCNT_W'(1);
                    end
                end
            end
            ARM: begin
                if (!IDL) begin
                    state_nxt = RECIRC;
                    scnt_nxt  = '0;
                end else if (scnt == SCNT_W'(SETTLE)) begin
                    state_nxt = ACTIVE;
                    scnt_nxt  = '0;
                end else begin
                    scnt_nxt  = scnt + SCNT_W'(1);
                end
            end
            ACTIVE: begin
                if (!IDL) begin
                    state_nxt = RECIRC;
                    scnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = RECIRC;
                scnt_nxt  = '0;
            end
        endcase
    end

    // Output decode: the word captured at this edge follows the state being
    // entered, so an IDL drop recirculates the same-cycle word with no drain.
    always_comb begin
        fwd_c = 1'b0;
        if (state_nxt == ACTIVE) begin
            fwd_c = 1'b1;
        end
    end

    // active tracks the path the registered outputs are using.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            active <= 1'b0;
        end else begin
            active <= fwd_c;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        recirc_lane #(
            .DW    (DW),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .reset_L  (reset_L),
            .fwd      (fwd_c),
            .vin      (valid_in[i]),
            .din      (data_in[i*DW +: DW]),
            .clr      (clr_cnt),
            .L1_data  (L1_data[i*DW +: DW]),
            .L1_valid (L1_valid[i]),
            .rc_data  (rc_data[i*DW +: DW]),
            .rc_valid (rc_valid[i]),
            .rc_cnt   (rc_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
